// File: rtl/elevator_pkg.sv
// elevator_pkg
// Shared definitions for the SCAN elevator controller: FSM state type with
// fixed encodings and the default values of the block parameters.
package elevator_pkg;

    localparam int DEF_NUM_FLOORS = 10;
    localparam int DEF_FLOOR_W    = 4;
    localparam int DEF_MOVE_TICKS = 16;
    localparam int DEF_DOOR_TICKS = 8;
    localparam int DEF_TMR_W      = 16;

    // HALT is only entered when the emergency-stop option is built in.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MOVE_UP   = 3'd1,
        MOVE_DOWN = 3'd2,
        DOOR_OPEN = 3'd3,
        HALT      = 3'd4
    } state_e;

endpackage

// File: rtl/elevator_call_reg.sv
// elevator_call_reg
// Latched call register. Sets a pending bit for every sampled call, clears
// the bit of the floor being served, and summarises the pending set relative
// to the car position.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   call_i       per-floor call requests, level-sampled every cycle
//   floor_i      floor the car is at
//   door_i       door is open and running; calls for floor_i are not latched
//   clr_i        clear the pending bit of clr_floor_i this edge
//   clr_floor_i  floor whose call is being served
//   pending_o    latched unserved calls
//   above_o      some pending floor lies above floor_i
//   below_o      some pending floor lies below floor_i
//   here_o       floor_i itself is pending
//   call_here_o  call_i is active for floor_i (raw, unlatched)
module elevator_call_reg
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int FLOOR_W    = DEF_FLOOR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_i,
    input  logic [FLOOR_W-1:0]    floor_i,
    input  logic                  door_i,
    input  logic                  clr_i,
    input  logic [FLOOR_W-1:0]    clr_floor_i,
    output logic [NUM_FLOORS-1:0] pending_o,
    output logic                  above_o,
    output logic                  below_o,
    output logic                  here_o,
    output logic                  call_here_o
);

    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [NUM_FLOORS-1:0] here_mask, clr_mask;

    always_comb begin
        // NOTE: every signal gets a default before any conditional update, so
        // no path leaves a value unassigned and no latch is inferred.
        here_mask = '0;
        clr_mask  = '0;
        above_o   = 1'b0;
        below_o   = 1'b0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            here_mask[f] = (FLOOR_W'(f) == floor_i);
            clr_mask[f]  = clr_i && (FLOOR_W'(f) == clr_floor_i);
            if (pending_q[f] && (FLOOR_W'(f) > floor_i)) above_o = 1'b1;
            if (pending_q[f] && (FLOOR_W'(f) < floor_i)) below_o = 1'b1;
        end
        here_o      = |(pending_q & here_mask);
        call_here_o = |(call_i & here_mask);
        // Serving a floor wins over a call for it arriving on the same edge.
        pending_d = (pending_q | (call_i & ~({NUM_FLOORS{door_i}} & here_mask)))
                    & ~clr_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers use non-blocking assignments so each one samples the
        // pre-edge value of everything it reads.
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl
// Multi-floor elevator controller: latched calls, SCAN scheduling (keep the
// current direction while calls remain ahead), per-floor travel time and a
// timed door dwell that restarts while the current floor is being called.
// Optional feature macro: ELEV_ESTOP_EN adds estop/halted and the HALT state.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   call           per-floor call requests
//   estop, halted  emergency stop input / HALT indicator (ELEV_ESTOP_EN only)
//   current_floor  floor the car is at or last passed
//   pending        latched unserved calls
//   dir_up         scan direction, 1 = up
//   moving         car travelling
//   door_open      door open
//   arrived        one-cycle pulse when the door opens for a served call
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int FLOOR_W    = DEF_FLOOR_W,
    parameter int MOVE_TICKS = DEF_MOVE_TICKS,
    parameter int DOOR_TICKS = DEF_DOOR_TICKS,
    parameter int TMR_W      = DEF_TMR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call,
`ifdef ELEV_ESTOP_EN
    input  logic                  estop,
    output logic                  halted,
`endif
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic                  arrived
);

    localparam logic [TMR_W-1:0]   MOVE_LAST = TMR_W'(MOVE_TICKS - 1);
    localparam logic [TMR_W-1:0]   DOOR_LAST = TMR_W'(DOOR_TICKS - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

    state_e             state_q, state_d, eff_state;
    logic [FLOOR_W-1:0] floor_q, floor_d, next_floor, clr_floor;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               dir_up_q, dir_up_d;
    logic               arrived_q, arrived_d;
    logic               clr, next_hit, door_active;
    logic               above, below, here, call_here;
`ifdef ELEV_ESTOP_EN
    state_e             saved_q, saved_d;
`endif

    elevator_call_reg #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_call_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .call_i      (call),
        .floor_i     (floor_q),
        .door_i      (door_active),
        .clr_i       (clr),
        .clr_floor_i (clr_floor),
        .pending_o   (pending),
        .above_o     (above),
        .below_o     (below),
        .here_o      (here),
        .call_here_o (call_here)
    );

    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        dir_up_d  = dir_up_q;
        timer_d   = timer_q;
        arrived_d = 1'b0;
        clr       = 1'b0;
        clr_floor = floor_q;
        eff_state = state_q;
`ifdef ELEV_ESTOP_EN
        saved_d = saved_q;
        // The release edge already acts as the saved state's edge, so a stop
        // of N cycles delays everything by exactly N cycles.
        if (state_q == HALT) eff_state = saved_q;
`endif
        // Saturating step keeps the floor inside 0..NUM_FLOORS-1.
        if (eff_state == MOVE_DOWN)
            next_floor = (floor_q == '0) ? floor_q : floor_q - FLOOR_W'(1);
        else
            next_floor = (floor_q == TOP_FLOOR) ? floor_q : floor_q + FLOOR_W'(1);
        next_hit = 1'b0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (pending[f] && (FLOOR_W'(f) == next_floor)) next_hit = 1'b1;
        end

`ifdef ELEV_ESTOP_EN
        if (estop) begin
            state_d = HALT;
            if (state_q != HALT) saved_d = state_q;
        end else
`endif
        begin
            state_d = eff_state;
            unique case (eff_state)
                IDLE: begin
                    if (here) begin
                        state_d   = DOOR_OPEN;
                        clr       = 1'b1;
                        arrived_d = 1'b1;
                        timer_d   = '0;
                    end else if (above && (dir_up_q || !below)) begin
                        state_d  = MOVE_UP;
                        dir_up_d = 1'b1;
                        timer_d  = '0;
                    end else if (below) begin
                        state_d  = MOVE_DOWN;
                        dir_up_d = 1'b0;
                        timer_d  = '0;
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (timer_q == MOVE_LAST) begin
                        timer_d = '0;
                        floor_d = next_floor;
                        if (next_hit) begin
                            state_d   = DOOR_OPEN;
                            clr       = 1'b1;
                            clr_floor = next_floor;
                            arrived_d = 1'b1;
                        // With next_floor not pending, calls beyond it are
                        // exactly the ones ahead of the current floor.
                        end else if (!((eff_state == MOVE_UP) ? above : below)) begin
                            state_d = IDLE;
                        end
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                DOOR_OPEN: begin
                    if (call_here) begin
                        timer_d = '0;
                    end else if (timer_q == DOOR_LAST) begin
                        state_d = IDLE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef ELEV_ESTOP_EN
    assign door_active = (eff_state == DOOR_OPEN) && !estop;
    assign halted      = (state_q == HALT);
`else
    assign door_active = (eff_state == DOOR_OPEN);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            floor_q   <= '0;
            dir_up_q  <= 1'b1;
            timer_q   <= '0;
            arrived_q <= 1'b0;
`ifdef ELEV_ESTOP_EN
            saved_q   <= IDLE;
`endif
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_up_q  <= dir_up_d;
            timer_q   <= timer_d;
            arrived_q <= arrived_d;
`ifdef ELEV_ESTOP_EN
            saved_q   <= saved_d;
`endif
        end
    end

    assign current_floor = floor_q;
    assign dir_up        = dir_up_q;
    assign arrived       = arrived_q;
    assign moving        = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
    assign door_open     = (state_q == DOOR_OPEN);

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// tb_elevator_scan_ctrl
// Directed bench for elevator_scan_ctrl at default parameters
// (10 floors, 16 cycles per floor, 8-cycle door dwell).
module tb_elevator_scan_ctrl;

    localparam int NF = 10;
    localparam int FW = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NF-1:0] call_s = '0;
    logic [FW-1:0] floor_s;
    logic [NF-1:0] pending_s;
    logic          dir_up_s, moving_s, door_s, arrived_s;
`ifdef ELEV_ESTOP_EN
    logic          estop_s = 1'b0;
    logic          halted_s;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    elevator_scan_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .call          (call_s),
`ifdef ELEV_ESTOP_EN
        .estop         (estop_s),
        .halted        (halted_s),
`endif
        .current_floor (floor_s),
        .pending       (pending_s),
        .dir_up        (dir_up_s),
        .moving        (moving_s),
        .door_open     (door_s),
        .arrived       (arrived_s)
    );

    typedef struct {
        logic [NF-1:0] call;
        int            steps;
        int            floor;
        logic [NF-1:0] pend;
        logic          dir;
        logic          mov;
        logic          door;
        logic          arr;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input int f, input logic [NF-1:0] p,
                               input logic d, input logic m, input logic o, input logic a);
        check({tag, " floor"},   32'(floor_s),   32'(f));
        check({tag, " pending"}, 32'(pending_s), 32'(p));
        check({tag, " dir_up"},  32'(dir_up_s),  32'(d));
        check({tag, " moving"},  32'(moving_s),  32'(m));
        check({tag, " door"},    32'(door_s),    32'(o));
        check({tag, " arrived"}, 32'(arrived_s), 32'(a));
    endtask

    // Outputs are sampled 1 time unit after the active edge.
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Steps until arrived pulses or the budget runs out; n is steps taken.
    task automatic wait_arrival(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (arrived_s !== 1'b1 && n < budget);
    endtask

    task automatic pulse_call(input logic [NF-1:0] c);
        call_s = c;
        step();
        call_s = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        // Single call for floor 3 from floor 0; call is held for the first step only.
        vecs[0] = '{10'h008,  1, 0, 10'h008, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{10'h000,  1, 0, 10'h008, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{10'h000, 15, 0, 10'h008, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{10'h000,  1, 1, 10'h008, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{10'h000, 16, 2, 10'h008, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{10'h000, 15, 2, 10'h008, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{10'h000,  1, 3, 10'h000, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{10'h000,  1, 3, 10'h000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{10'h000,  6, 3, 10'h000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{10'h000,  1, 3, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0};

        step(2);
        check_state("reset", 0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            pulse_call(vecs[i].call);
            if (vecs[i].steps > 1) step(vecs[i].steps - 1);
            check_state($sformatf("vec%0d", i), vecs[i].floor, vecs[i].pend,
                        vecs[i].dir, vecs[i].mov, vecs[i].door, vecs[i].arr);
        end

        // Back to floor 0; calls for 5 and 2 together are served 2 then 5.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        pulse_call(10'h024);
        check("s2 latched", 32'(pending_s), 32'h024);
        wait_arrival(100, n);
        check("s2 cycles to 2", 32'(n), 32'd33);
        check_state("s2 at2", 2, 10'h020, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_arrival(100, n);
        check("s2 cycles to 5", 32'(n), 32'd57);
        check_state("s2 at5", 5, 10'h000, 1'b1, 1'b0, 1'b1, 1'b1);

        // Heading 5 -> 8, floor 1 called while passing 6: serve 8 first.
        step(7);
        check("s3 door last cycle", 32'(door_s), 32'd1);
        step();
        check_state("s3 closed", 5, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_call(10'h100);
        step(17);
        check_state("s3 pass6", 6, 10'h100, 1'b1, 1'b1, 1'b0, 1'b0);
        pulse_call(10'h002);
        check("s3 latched", 32'(pending_s), 32'h102);
        wait_arrival(100, n);
        check("s3 cycles to 8", 32'(n), 32'd31);
        check_state("s3 at8", 8, 10'h002, 1'b1, 1'b0, 1'b1, 1'b1);
        step(8);
        check_state("s3 idle8", 8, 10'h002, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check_state("s3 down", 8, 10'h002, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_arrival(200, n);
        check("s3 cycles to 1", 32'(n), 32'd112);
        check_state("s3 at1", 1, 10'h000, 1'b0, 1'b0, 1'b1, 1'b1);

        // Holding the current floor's call keeps the door open without latching.
        call_s = 10'h002;
        for (int i = 0; i < 12; i++) begin
            step();
            check($sformatf("s4 hold%0d door", i), 32'(door_s), 32'd1);
            check($sformatf("s4 hold%0d pending", i), 32'(pending_s), 32'd0);
        end
        call_s = '0;
        step(7);
        check("s4 door after release", 32'(door_s), 32'd1);
        step();
        check_state("s4 closed", 1, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Top floor, then back down to floor 0.
        pulse_call(10'h200);
        check("s5 latched top", 32'(pending_s), 32'h200);
        step();
        check_state("s5 up", 1, 10'h200, 1'b1, 1'b1, 1'b0, 1'b0);
        pulse_call(10'h001);
        check("s5 latched both", 32'(pending_s), 32'h201);
        wait_arrival(300, n);
        check("s5 cycles to top", 32'(n), 32'd127);
        check_state("s5 top", 9, 10'h001, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_arrival(300, n);
        check("s5 cycles to bottom", 32'(n), 32'd153);
        check_state("s5 bottom", 0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b1);
        step(8);
        check_state("s5 closed", 0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Call for the current floor while idle: door two edges later.
        pulse_call(10'h001);
        check_state("here latched", 0, 10'h001, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_state("here door", 0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset with door open and a call pending.
        pulse_call(10'h040);
        check("rst pre pending", 32'(pending_s), 32'h040);
        rst_n = 1'b0;
        #1;
        check_state("rst door", 0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        step(3);
        check_state("rst discard", 0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset while travelling.
        pulse_call(10'h010);
        step(21);
        check("rst pre move floor", 32'(floor_s), 32'd1);
        rst_n = 1'b0;
        #1;
        check_state("rst move", 0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;

`ifdef ELEV_ESTOP_EN
        // 20-cycle emergency stop mid-travel delays arrival by exactly 20 cycles.
        pulse_call(10'h004);
        step();
        check("es moving", 32'(moving_s), 32'd1);
        step(10);
        estop_s = 1'b1;
        step();
        check_state("es halt", 0, 10'h004, 1'b1, 1'b0, 1'b0, 1'b0);
        check("es halted", 32'(halted_s), 32'd1);
        pulse_call(10'h020);
        check("es latched in halt", 32'(pending_s), 32'h024);
        step(18);
        check_state("es hold", 0, 10'h024, 1'b1, 1'b0, 1'b0, 1'b0);
        check("es still halted", 32'(halted_s), 32'd1);
        estop_s = 1'b0;
        wait_arrival(100, n);
        check("es cycles to 2", 32'(n), 32'd22);
        check_state("es at2", 2, 10'h020, 1'b1, 1'b0, 1'b1, 1'b1);
        check("es released", 32'(halted_s), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
